// File: rtl/pomodoro_pkg.sv
// pomodoro_pkg: phase/state enums, LED colors and phase-length-to-mm:ss helper
package pomodoro_pkg;
  typedef enum logic [1:0] {PH_WORK = 2'd0, PH_SHORT = 2'd1, PH_LONG = 2'd2} phase_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_PAUSE = 2'd2, ST_ALERT = 2'd3} state_e;
  localparam logic [2:0] RGB_WORK  = 3'b100;
  localparam logic [2:0] RGB_SHORT = 3'b010;
  localparam logic [2:0] RGB_LONG  = 3'b001;
  localparam logic [2:0] RGB_OFF   = 3'b000;
  localparam logic [2:0] RGB_ALERT = 3'b111;
  function automatic logic [12:0] phase_time(input phase_e p, input int w, input int s, input int l);
    int len;
    len = p == PH_WORK ? w : p == PH_SHORT ? s : l;
    return {7'(len / 60), 6'(len % 60)};
  endfunction
endpackage

// File: rtl/mmss_down_counter.sv
// mmss_down_counter: min/sec registers (clk, rst, load ld_min/ld_sec, dec) with o_min/o_sec and zero/one detect
module mmss_down_counter #(
  parameter logic [6:0] RST_MIN = 7'd0,
  parameter logic [5:0] RST_SEC = 6'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] ld_min,
  input  logic [5:0] ld_sec,
  input  logic       dec,
  output logic [6:0] o_min,
  output logic [5:0] o_sec,
  output logic       o_zero,
  output logic       o_one
);
  logic [6:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  always_comb begin
    min_d = load ? ld_min : dec && sec_q == 6'd0 ? min_q - 7'd1 : min_q;
    sec_d = load ? ld_sec : !dec ? sec_q : sec_q == 6'd0 ? 6'd59 : sec_q - 6'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= RST_MIN;
      sec_q <= RST_SEC;
    end else begin
      min_q <= min_d;
      sec_q <= sec_d;
    end
  end
  assign o_min  = min_q;
  assign o_sec  = sec_q;
  assign o_zero = min_q == 7'd0 && sec_q == 6'd0;
  assign o_one  = min_q == 7'd0 && sec_q == 6'd1;
endmodule

// File: rtl/pomodoro_phase_ctrl.sv
// pomodoro_phase_ctrl: work/break phase sequencer; buttons in, phase/state/mm:ss/work_cnt/rgb/beep/done registered out
module pomodoro_phase_ctrl
  import pomodoro_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int TICK_DIV        = CLK_FREQ_HZ,
  parameter int WORK_S          = 1500,
  parameter int SHORT_S         = 300,
  parameter int LONG_S          = 900,
  parameter int CYCLES_PER_LONG = 4,
  parameter int ALERT_CYC       = CLK_FREQ_HZ / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_toggle,
  input  logic       i_skip,
  input  logic       i_clear,
  output logic [1:0] o_phase,
  output logic [1:0] o_state,
  output logic [6:0] o_min,
  output logic [5:0] o_sec,
  output logic [2:0] o_work_cnt,
  output logic [2:0] o_rgb,
  output logic       o_beep,
  output logic       o_done
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int AW = $clog2(ALERT_CYC + 1);
  localparam logic [12:0] WORK_T = phase_time(PH_WORK, WORK_S, SHORT_S, LONG_S);
  state_e state_q, state_d;
  phase_e phase_q, phase_d, nxt_ph;
  logic [2:0] cnt_q, cnt_d, nxt_cnt;
  logic [PW-1:0] presc_q, presc_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic beep_q, beep_d, done_q, done_d;
  logic [2:0] rgb_q, rgb_d;
  logic tick, ld, dec, zero, one;
  logic [12:0] ld_t;
  mmss_down_counter #(.RST_MIN(WORK_T[12:6]), .RST_SEC(WORK_T[5:0])) u_cnt (
    .clk(clk), .rst(rst), .load(ld), .ld_min(ld_t[12:6]), .ld_sec(ld_t[5:0]), .dec(dec),
    .o_min(o_min), .o_sec(o_sec), .o_zero(zero), .o_one(one)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= PH_WORK;
      cnt_q   <= '0;
      presc_q <= '0;
      acnt_q  <= '0;
      beep_q  <= 1'b0;
      done_q  <= 1'b0;
      rgb_q   <= RGB_WORK;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      acnt_q  <= acnt_d;
      beep_q  <= beep_d;
      done_q  <= done_d;
      rgb_q   <= rgb_d;
    end
  end
  always_comb begin
    nxt_cnt = phase_q == PH_WORK ? cnt_q + 3'd1 : cnt_q;
    nxt_ph  = phase_q != PH_WORK ? PH_WORK : nxt_cnt == 3'(CYCLES_PER_LONG) ? PH_LONG : PH_SHORT;
    nxt_cnt = nxt_ph == PH_LONG ? 3'd0 : nxt_cnt;
    tick    = state_q == ST_RUN && presc_q == PW'(TICK_DIV - 1);
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    presc_d = presc_q;
    acnt_d  = acnt_q;
    beep_d  = beep_q;
    done_d  = 1'b0;
    dec     = 1'b0;
    // ALERT keeps reloading the already-advanced phase so mm:ss shows the next time
    ld      = state_q == ST_ALERT;
    ld_t    = phase_time(phase_q, WORK_S, SHORT_S, LONG_S);
    if (i_clear) begin
      state_d = ST_IDLE;
      phase_d = PH_WORK;
      cnt_d   = '0;
      beep_d  = 1'b0;
      ld      = 1'b1;
      ld_t    = WORK_T;
    end else if (i_skip) begin
      state_d = ST_IDLE;
      beep_d  = 1'b0;
      if (state_q != ST_ALERT) begin
        phase_d = nxt_ph;
        cnt_d   = nxt_cnt;
        ld      = 1'b1;
        ld_t    = phase_time(nxt_ph, WORK_S, SHORT_S, LONG_S);
      end
    end else if (i_toggle) begin
      state_d = state_q == ST_RUN ? ST_PAUSE : state_q == ST_ALERT ? ST_IDLE : ST_RUN;
      presc_d = state_q == ST_IDLE ? '0 : presc_q;
      beep_d  = state_q == ST_ALERT ? 1'b0 : beep_q;
    end else if (state_q == ST_ALERT) begin
      state_d = acnt_q == '0 ? ST_IDLE : ST_ALERT;
      beep_d  = acnt_q != '0;
      acnt_d  = acnt_q == '0 ? acnt_q : acnt_q - AW'(1);
    end else if (tick) begin
      presc_d = '0;
      dec     = !zero;
      if (one) begin
        state_d = ST_ALERT;
        phase_d = nxt_ph;
        cnt_d   = nxt_cnt;
        beep_d  = 1'b1;
        done_d  = 1'b1;
        acnt_d  = AW'(ALERT_CYC - 1);
      end
    end else if (state_q == ST_RUN) begin
      presc_d = presc_q + PW'(1);
    end
  end
  always_comb begin
    rgb_d = state_d == ST_ALERT ? RGB_ALERT :
            state_d == ST_PAUSE ? RGB_OFF :
            phase_d == PH_WORK  ? RGB_WORK :
            phase_d == PH_SHORT ? RGB_SHORT : RGB_LONG;
  end
  assign o_phase    = phase_q;
  assign o_state    = state_q;
  assign o_work_cnt = cnt_q;
  assign o_rgb      = rgb_q;
  assign o_beep     = beep_q;
  assign o_done     = done_q;
endmodule

// File: tb/tb_pomodoro_phase_ctrl.sv
// tb_pomodoro_phase_ctrl: directed scenario bench for pomodoro_phase_ctrl
module tb_pomodoro_phase_ctrl;
  logic clk = 1'b0, rst = 1'b1, i_toggle = 1'b0, i_skip = 1'b0, i_clear = 1'b0;
  logic [1:0] o_phase, o_state;
  logic [6:0] o_min;
  logic [5:0] o_sec;
  logic [2:0] o_work_cnt, o_rgb;
  logic o_beep, o_done;
  logic [24:0] snap;
  int checks = 0, errors = 0;
  pomodoro_phase_ctrl #(
    .TICK_DIV(4), .WORK_S(3), .SHORT_S(2), .LONG_S(65), .CYCLES_PER_LONG(2), .ALERT_CYC(5)
  ) dut (
    .clk(clk), .rst(rst), .i_toggle(i_toggle), .i_skip(i_skip), .i_clear(i_clear),
    .o_phase(o_phase), .o_state(o_state), .o_min(o_min), .o_sec(o_sec),
    .o_work_cnt(o_work_cnt), .o_rgb(o_rgb), .o_beep(o_beep), .o_done(o_done)
  );
  always #5 clk = ~clk;
  assign snap = {o_state, o_phase, o_min, o_sec, o_work_cnt, o_rgb, o_beep, o_done};
  function automatic logic [24:0] ex(input int st, ph, mi, se, wc, input logic [2:0] rgb, input logic bp, dn);
    return {2'(st), 2'(ph), 7'(mi), 6'(se), 3'(wc), rgb, bp, dn};
  endfunction
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic t, s, c);
    i_toggle = t;
    i_skip = s;
    i_clear = c;
    step(1);
    i_toggle = 1'b0;
    i_skip = 1'b0;
    i_clear = 1'b0;
  endtask
  task automatic wait_state(input logic [1:0] st, output bit ok);
    int n;
    n = 0;
    while (o_state !== st && n < 200) begin
      step(1);
      n++;
    end
    ok = o_state === st;
  endtask
  task automatic test_reset;
    logic [24:0] e;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    e = ex(0, 0, 0, 3, 0, 3'b100, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL reset got %h exp %h", snap, e); end
    step(1);
    checks++; if (snap !== e) begin errors++; $display("FAIL reset_hold got %h exp %h", snap, e); end
  endtask
  task automatic test_work_phase;
    logic [24:0] e;
    pulse(1, 0, 0);
    e = ex(1, 0, 0, 3, 0, 3'b100, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL run_start got %h exp %h", snap, e); end
    step(3);
    checks++; if (snap !== e) begin errors++; $display("FAIL pre_tick got %h exp %h", snap, e); end
    step(1);
    e = ex(1, 0, 0, 2, 0, 3'b100, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL first_dec got %h exp %h", snap, e); end
    step(7);
    e = ex(1, 0, 0, 1, 0, 3'b100, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL pre_done got %h exp %h", snap, e); end
    step(1);
    e = ex(3, 1, 0, 0, 1, 3'b111, 1, 1);
    checks++; if (snap !== e) begin errors++; $display("FAIL done got %h exp %h", snap, e); end
    step(4);
    e = ex(3, 1, 0, 2, 1, 3'b111, 1, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL beep_last got %h exp %h", snap, e); end
    step(1);
    e = ex(0, 1, 0, 2, 1, 3'b010, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL alert_end got %h exp %h", snap, e); end
  endtask
  task automatic test_long_borrow;
    logic [24:0] e;
    bit ok;
    pulse(1, 0, 0);
    wait_state(2'd3, ok);
    checks++; if (!ok) begin errors++; $display("FAIL short_alert state %0d exp 3", o_state); end
    step(1);
    wait_state(2'd0, ok);
    e = ex(0, 0, 0, 3, 1, 3'b100, 0, 0);
    checks++; if (!ok || snap !== e) begin errors++; $display("FAIL after_short got %h exp %h", snap, e); end
    pulse(1, 0, 0);
    wait_state(2'd3, ok);
    e = ex(3, 2, 0, 0, 0, 3'b111, 1, 1);
    checks++; if (!ok || snap !== e) begin errors++; $display("FAIL long_sel got %h exp %h", snap, e); end
    step(1);
    wait_state(2'd0, ok);
    e = ex(0, 2, 1, 5, 0, 3'b001, 0, 0);
    checks++; if (!ok || snap !== e) begin errors++; $display("FAIL long_load got %h exp %h", snap, e); end
    pulse(1, 0, 0);
    step(20);
    e = ex(1, 2, 1, 0, 0, 3'b001, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL long_1m got %h exp %h", snap, e); end
    step(4);
    e = ex(1, 2, 0, 59, 0, 3'b001, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL borrow got %h exp %h", snap, e); end
  endtask
  task automatic test_pause;
    logic [24:0] e;
    pulse(0, 0, 1);
    e = ex(0, 0, 0, 3, 0, 3'b100, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL clear got %h exp %h", snap, e); end
    pulse(1, 0, 0);
    step(2);
    pulse(1, 0, 0);
    e = ex(2, 0, 0, 3, 0, 3'b000, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL pause got %h exp %h", snap, e); end
    step(20);
    checks++; if (snap !== e) begin errors++; $display("FAIL pause_hold got %h exp %h", snap, e); end
    pulse(1, 0, 0);
    e = ex(1, 0, 0, 3, 0, 3'b100, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL resume got %h exp %h", snap, e); end
    step(1);
    checks++; if (snap !== e) begin errors++; $display("FAIL resume_wait got %h exp %h", snap, e); end
    step(1);
    e = ex(1, 0, 0, 2, 0, 3'b100, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL resume_dec got %h exp %h", snap, e); end
  endtask
  task automatic test_clear_priority;
    logic [24:0] e;
    pulse(0, 1, 0);
    e = ex(0, 1, 0, 2, 1, 3'b010, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL skip_run got %h exp %h", snap, e); end
    pulse(1, 0, 0);
    step(2);
    pulse(1, 1, 1);
    e = ex(0, 0, 0, 3, 0, 3'b100, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL clear_prio got %h exp %h", snap, e); end
    step(1);
    checks++; if (snap !== e) begin errors++; $display("FAIL clear_quiet got %h exp %h", snap, e); end
  endtask
  task automatic test_skip_alert;
    logic [24:0] e;
    bit ok;
    pulse(1, 0, 0);
    wait_state(2'd3, ok);
    e = ex(3, 1, 0, 0, 1, 3'b111, 1, 1);
    checks++; if (!ok || snap !== e) begin errors++; $display("FAIL alert_entry got %h exp %h", snap, e); end
    pulse(0, 1, 0);
    e = ex(0, 1, 0, 2, 1, 3'b010, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL skip_alert got %h exp %h", snap, e); end
  endtask
  task automatic test_toggle_alert;
    logic [24:0] e;
    bit ok;
    pulse(1, 0, 0);
    wait_state(2'd3, ok);
    step(1);
    pulse(1, 0, 0);
    e = ex(0, 0, 0, 3, 1, 3'b100, 0, 0);
    checks++; if (!ok || snap !== e) begin errors++; $display("FAIL ack_alert got %h exp %h", snap, e); end
  endtask
  task automatic test_reset_mid;
    logic [24:0] e;
    pulse(1, 0, 0);
    step(6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    e = ex(0, 0, 0, 3, 0, 3'b100, 0, 0);
    checks++; if (snap !== e) begin errors++; $display("FAIL reset_mid got %h exp %h", snap, e); end
  endtask
  initial begin
    test_reset;
    test_work_phase;
    test_long_borrow;
    test_pause;
    test_clear_priority;
    test_skip_alert;
    test_toggle_alert;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
